// File: rtl/mmm_pkg.sv
`default_nettype none
// ============================================================================
// mmm_pkg : shared types and sizing helpers for the MMM operand path
// Rev 1.0
// ============================================================================
package mmm_pkg;

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_LOAD_A = 2'd1,
    ST_LOAD_B = 2'd2,
    ST_LOADED = 2'd3
  } loader_state_t;

  localparam int C_DEF_M    = 7;
  localparam int C_DEF_N    = 9;
  localparam int C_DEF_MAXK = 8;

  // A one-entry RAM still needs a one-bit address.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int C_DEF_A_AW = addr_bits(C_DEF_M * C_DEF_MAXK);
  localparam int C_DEF_B_AW = addr_bits(C_DEF_MAXK * C_DEF_N);

endpackage
`default_nettype wire

// File: rtl/operand_ram.sv
`default_nettype none
// ============================================================================
// operand_ram : one write port, one read-first read port, 1-cycle read latency
// Rev 1.0
// ============================================================================
module operand_ram
  import mmm_pkg::*;
#(
  parameter int  WIDTH = 12,
  parameter int  DEPTH = 56,
  localparam int AW    = addr_bits(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Read and write share one process so a colliding read sees the old word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule
`default_nettype wire

// File: rtl/operand_loader.sv
`default_nettype none
// ============================================================================
// operand_loader : streams A (MxK) and B (KxN) into RAMs and serves reads
// Rev 1.0
// ============================================================================
module operand_loader
  import mmm_pkg::*;
#(
  parameter int  INW    = 12,
  parameter int  M      = C_DEF_M,
  parameter int  N      = C_DEF_N,
  parameter int  MAXK   = C_DEF_MAXK,
  localparam int K_BITS = $clog2(MAXK + 1),
  localparam int A_AW   = addr_bits(M * MAXK),
  localparam int B_AW   = addr_bits(MAXK * N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INW-1:0]    AXIS_TDATA,
  input  logic              AXIS_TVALID,
  input  logic [K_BITS:0]   AXIS_TUSER,
  output logic              AXIS_TREADY,
  output logic              matrices_loaded,
  input  logic              compute_finished,
  output logic [K_BITS-1:0] K,
  input  logic [A_AW-1:0]   A_read_addr,
  output logic [INW-1:0]    A_data,
  input  logic [B_AW-1:0]   B_read_addr,
  output logic [INW-1:0]    B_data
);

  loader_state_t     r_state;
  logic [A_AW-1:0]   r_a_cnt;
  logic [B_AW-1:0]   r_b_cnt;
  logic [K_BITS-1:0] r_k;
  logic              r_first;

  logic              w_hs;
  logic              w_new_a;
  logic [K_BITS-1:0] w_user_k;
  logic [K_BITS-1:0] w_k_eff;
  logic [15:0]       w_a_total;
  logic [15:0]       w_b_total;
  logic              w_a_last;
  logic              w_b_last;
  logic              w_a_we;
  logic              w_b_we;

  assign AXIS_TREADY     = (r_state != ST_LOADED);
  assign matrices_loaded = (r_state == ST_LOADED);
  assign K               = r_k;

  assign w_hs     = AXIS_TVALID & AXIS_TREADY;
  assign w_user_k = AXIS_TUSER[K_BITS:1];
  assign w_new_a  = AXIS_TUSER[0] | r_first;

  // In START the counters sit at 0, so the "last word" tests also cover
  // the degenerate single-word matrices without extra cases.
  assign w_k_eff   = (r_state == ST_START && w_new_a) ? w_user_k : r_k;
  assign w_a_total = 16'(M) * 16'(w_k_eff);
  assign w_b_total = 16'(N) * 16'(w_k_eff);
  assign w_a_last  = (16'(r_a_cnt) + 16'd1) == w_a_total;
  assign w_b_last  = (16'(r_b_cnt) + 16'd1) == w_b_total;

  assign w_a_we = w_hs & (((r_state == ST_START) & w_new_a) | (r_state == ST_LOAD_A));
  assign w_b_we = w_hs & (((r_state == ST_START) & ~w_new_a) | (r_state == ST_LOAD_B));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_START;
      r_a_cnt <= '0;
      r_b_cnt <= '0;
      r_k     <= '0;
      r_first <= 1'b1;
    end else begin
      case (r_state)
        ST_START: begin
          if (w_hs) begin
            r_first <= 1'b0;
            if (w_new_a) begin
              r_k <= w_user_k;
              if (w_a_last) begin
                r_state <= ST_LOAD_B;
              end else begin
                r_state <= ST_LOAD_A;
                r_a_cnt <= r_a_cnt + 1'b1;
              end
            end else if (w_b_last) begin
              r_state <= ST_LOADED;
            end else begin
              r_state <= ST_LOAD_B;
              r_b_cnt <= r_b_cnt + 1'b1;
            end
          end
        end
        ST_LOAD_A: begin
          if (w_hs) begin
            if (w_a_last) begin
              r_state <= ST_LOAD_B;
              r_a_cnt <= '0;
            end else begin
              r_a_cnt <= r_a_cnt + 1'b1;
            end
          end
        end
        ST_LOAD_B: begin
          if (w_hs) begin
            if (w_b_last) begin
              r_state <= ST_LOADED;
              r_b_cnt <= '0;
            end else begin
              r_b_cnt <= r_b_cnt + 1'b1;
            end
          end
        end
        ST_LOADED: begin
          if (compute_finished) begin
            r_state <= ST_START;
          end
        end
      endcase
    end
  end

  operand_ram #(.WIDTH(INW), .DEPTH(M * MAXK)) u_ram_a (
    .clk     (clk),
    .i_we    (w_a_we),
    .i_waddr (r_a_cnt),
    .i_wdata (AXIS_TDATA),
    .i_raddr (A_read_addr),
    .o_rdata (A_data)
  );

  operand_ram #(.WIDTH(INW), .DEPTH(MAXK * N)) u_ram_b (
    .clk     (clk),
    .i_we    (w_b_we),
    .i_waddr (r_b_cnt),
    .i_wdata (AXIS_TDATA),
    .i_raddr (B_read_addr),
    .o_rdata (B_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// ============================================================================
// tb_operand_loader : directed scoreboard bench for operand_loader
// Rev 1.0
// ============================================================================
module tb_operand_loader;

  localparam int INW = 12, M = 7, N = 9, MAXK = 8, K_BITS = 4, A_AW = 6, B_AW = 7;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [INW-1:0]    AXIS_TDATA = '0;
  logic              AXIS_TVALID = 1'b0;
  logic [K_BITS:0]   AXIS_TUSER = '0;
  logic              AXIS_TREADY;
  logic              matrices_loaded;
  logic              compute_finished = 1'b0;
  logic [K_BITS-1:0] K;
  logic [A_AW-1:0]   A_read_addr = '0;
  logic [INW-1:0]    A_data;
  logic [B_AW-1:0]   B_read_addr = '0;
  logic [INW-1:0]    B_data;

  int errors = 0;
  int checks = 0;
  logic [31:0] q_exp[$];
  string       q_tag[$];

  operand_loader #(.INW(INW), .M(M), .N(N), .MAXK(MAXK)) dut (
    .clk              (clk),
    .reset            (reset),
    .AXIS_TDATA       (AXIS_TDATA),
    .AXIS_TVALID      (AXIS_TVALID),
    .AXIS_TUSER       (AXIS_TUSER),
    .AXIS_TREADY      (AXIS_TREADY),
    .matrices_loaded  (matrices_loaded),
    .compute_finished (compute_finished),
    .K                (K),
    .A_read_addr      (A_read_addr),
    .A_data           (A_data),
    .B_read_addr      (B_read_addr),
    .B_data           (B_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [INW-1:0] d, input logic [K_BITS:0] u);
    bit rdy;
    bit got;
    got = 1'b0;
    AXIS_TDATA  = d;
    AXIS_TUSER  = u;
    AXIS_TVALID = 1'b1;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      rdy = AXIS_TREADY;
      @(posedge clk);
      #1;
      got = rdy;
    end
    AXIS_TVALID = 1'b0;
    check("push_accepted", {31'b0, got}, 32'd1);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_cf();
    compute_finished = 1'b1;
    @(posedge clk);
    #1;
    compute_finished = 1'b0;
  endtask

  task automatic rd(input bit is_b, input int addr, input logic [INW-1:0] exp, input string tag);
    if (is_b) B_read_addr = addr[B_AW-1:0];
    else      A_read_addr = addr[A_AW-1:0];
    q_exp.push_back({20'b0, exp});
    q_tag.push_back(tag);
    @(posedge clk);
    #1;
    check(q_tag.pop_front(), is_b ? {20'b0, B_data} : {20'b0, A_data}, q_exp.pop_front());
  endtask

  initial begin
    bit ok;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_tready", {31'b0, AXIS_TREADY}, 32'd1);
    check("rst_loaded", {31'b0, matrices_loaded}, 32'd0);
    check("rst_k", {28'b0, K}, 32'd0);

    // Full load, K=4
    for (int i = 0; i < 28; i++) push(12'(i), {4'd4, 1'b1});
    for (int i = 0; i < 35; i++) push(12'(100 + i), 5'd0);
    check("t1_not_early", {31'b0, matrices_loaded}, 32'd0);
    check("t1_ready_before_last", {31'b0, AXIS_TREADY}, 32'd1);
    push(12'd135, 5'd0);
    check("t1_tready_low", {31'b0, AXIS_TREADY}, 32'd0);
    check("t1_loaded", {31'b0, matrices_loaded}, 32'd1);
    check("t1_k", {28'b0, K}, 32'd4);
    rd(1'b0, 5, 12'd5, "t1_a5");
    rd(1'b1, 35, 12'd135, "t1_b35");
    rd(1'b1, 0, 12'd100, "t1_b0");

    // Reuse A: only B streamed, TUSER K ignored
    pulse_cf();
    check("t2_cf_loaded", {31'b0, matrices_loaded}, 32'd0);
    check("t2_cf_tready", {31'b0, AXIS_TREADY}, 32'd1);
    for (int i = 0; i < 35; i++) push(12'(200 + i), {4'd7, 1'b0});
    check("t2_not_early", {31'b0, matrices_loaded}, 32'd0);
    push(12'd235, {4'd7, 1'b0});
    check("t2_loaded", {31'b0, matrices_loaded}, 32'd1);
    check("t2_k", {28'b0, K}, 32'd4);
    rd(1'b0, 5, 12'd5, "t2_a5");
    rd(1'b0, 27, 12'd27, "t2_a27");
    rd(1'b1, 0, 12'd200, "t2_b0");
    rd(1'b1, 35, 12'd235, "t2_b35");

    // Random TVALID gaps, K=8
    pulse_cf();
    ok = 1'b1;
    for (int i = 0; i < 56 + 72; i++) begin
      while ($urandom_range(0, 9) < 3) idle();
      if (!AXIS_TREADY) ok = 1'b0;
      if (i < 56) push(12'(300 + i), {4'd8, 1'b1});
      else        push(12'(4095 - (i - 56)), 5'd0);
    end
    check("t3_tready_held", {31'b0, ok}, 32'd1);
    check("t3_loaded", {31'b0, matrices_loaded}, 32'd1);
    check("t3_k", {28'b0, K}, 32'd8);
    for (int i = 0; i < 56; i++) rd(1'b0, i, 12'(300 + i), "t3_a");
    for (int i = 0; i < 72; i++) rd(1'b1, i, 12'(4095 - i), "t3_b");

    // Backpressure in LOADED
    AXIS_TDATA  = 12'h123;
    AXIS_TUSER  = {4'd2, 1'b1};
    AXIS_TVALID = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (AXIS_TREADY) ok = 1'b0;
      @(posedge clk);
      #1;
    end
    check("t4_no_handshake", {31'b0, ok}, 32'd1);
    rd(1'b0, 0, 12'd300, "t4_a0_kept");
    rd(1'b1, 71, 12'(4095 - 71), "t4_b71_kept");
    compute_finished = 1'b1;
    @(posedge clk);
    #1;
    compute_finished = 1'b0;
    check("t4_tready_after_cf", {31'b0, AXIS_TREADY}, 32'd1);
    push(12'h123, {4'd2, 1'b1});
    check("t4_k", {28'b0, K}, 32'd2);
    rd(1'b0, 0, 12'h123, "t4_a0_new");
    rd(1'b0, 1, 12'd301, "t4_a1_old");
    for (int i = 1; i < 10; i++) push(12'(i), 5'd0);

    // Reset mid-load
    reset = 1'b1;
    idle();
    reset = 1'b0;
    check("t5_rst_tready", {31'b0, AXIS_TREADY}, 32'd1);
    check("t5_rst_loaded", {31'b0, matrices_loaded}, 32'd0);
    check("t5_rst_k", {28'b0, K}, 32'd0);

    // K=1 with signed extremes; new_A=0 on first word after reset
    push(12'h800, {4'd1, 1'b0});
    check("t6_k_captured", {28'b0, K}, 32'd1);
    for (int i = 1; i < 7; i++) begin
      if (i == 3) begin
        pulse_cf();
        check("t6_cf_ignored_ready", {31'b0, AXIS_TREADY}, 32'd1);
        check("t6_cf_ignored_loaded", {31'b0, matrices_loaded}, 32'd0);
      end
      push((i % 2) ? 12'h7FF : 12'h800, 5'd0);
    end
    for (int i = 0; i < 8; i++) push((i % 2) ? 12'h7FF : 12'h800, 5'd0);
    check("t6_not_early", {31'b0, matrices_loaded}, 32'd0);
    push(12'h800, 5'd0);
    check("t6_loaded", {31'b0, matrices_loaded}, 32'd1);
    check("t6_tready", {31'b0, AXIS_TREADY}, 32'd0);
    check("t6_k", {28'b0, K}, 32'd1);
    rd(1'b0, 0, 12'h800, "t6_a0");
    rd(1'b0, 1, 12'h7FF, "t6_a1");
    rd(1'b0, 6, 12'h800, "t6_a6");
    rd(1'b1, 0, 12'h800, "t6_b0");
    rd(1'b1, 1, 12'h7FF, "t6_b1");
    rd(1'b1, 8, 12'h800, "t6_b8");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
